tick_gen: RTL and testbench
===========================

Name: tick_gen

Overview:
Programmable tick generator that sits directly upstream of the counter and drives its en input.
- Divides clk by a programmable ratio and emits single-cycle tick pulses.
- Either emits a fixed number of ticks (burst) or runs until stopped.
- Start/stop control with busy and done status, so software or an FSM can meter exactly how many counter increments occur.

Parameters:
DIV_WIDTH, 8, width of the divide-ratio input div; max period 2^DIV_WIDTH-1 cycles.
CNT_WIDTH, 8, width of the burst-length input n_ticks and the remaining output.

Ports:
clk  input  1  system clock; all logic on rising edge.
rst  input  1  reset; asynchronous, active-high.
start  input  1  one-cycle request; sampled only in IDLE.
stop  input  1  abort request; sampled only in RUN.
div  input  DIV_WIDTH  tick period in clk cycles; 0 treated as 1.
n_ticks  input  CNT_WIDTH  burst length; 0 = free-run until stop.
tick  output  1  registered one-cycle pulse; connects to counter en.
busy  output  1  high while in RUN.
done  output  1  one-cycle pulse coincident with the final tick of a burst.
remaining  output  CNT_WIDTH  ticks still to issue (0 in free-run and in IDLE).

Behaviour:
- Reset (async assert, sync release): state=IDLE, tick=0, busy=0, done=0, remaining=0, prescaler=0.
- States: IDLE, RUN. Held in shared enum.
- IDLE -> RUN on edge with start=1 (edge E0).
  - Latch div_eff = (div==0) ? 1 : div.
  - Latch remaining = n_ticks and set free = (n_ticks==0).
  - Clear prescaler; busy=1 after E0.
- Inputs div and n_ticks are ignored after E0 until the next start.
- RUN, each edge:
  - If prescaler == div_eff-1: prescaler <= 0 and tick <= 1. If not free, remaining <= remaining-1.
  - Otherwise prescaler++ and tick <= 0.
- Latency: first tick is high in the cycle after edge E(div_eff). Subsequent ticks follow every div_eff cycles. With div_eff=1, tick is continuously high.
- Burst end: at the edge that issues a tick with remaining==1 (not free):
  - tick <= 1, done <= 1, remaining <= 0, state <= IDLE, busy <= 0.
  - done and the final tick share a cycle.
- Stop in RUN: at that edge, state <= IDLE, busy <= 0, remaining <= 0, prescaler <= 0, done stays 0.
  - If the same edge would have issued a tick, the tick is still issued; stop does not suppress an already-due tick.
  - If the same edge would have been the burst end, done is still asserted (completion wins).
- start while in RUN: ignored, no restart.
- stop while in IDLE: ignored.
- start and stop in the same IDLE cycle: start accepted (stop not sampled in IDLE).
- start in the cycle where done=1: accepted. The block is already in IDLE, so back-to-back bursts have zero idle gap apart from prescaler refill.
- Reset mid-RUN: immediate return to reset values; any partial period is discarded and no done is produced.
- Arithmetic: prescaler is DIV_WIDTH bits and never exceeds div_eff-1. remaining never underflows; decrement is gated by remaining!=0.

Decomposition:
- Package tick_gen_pkg contains:
  - typedef enum logic {IDLE, RUN} tick_gen_state_t
  - localparam defaults for DIV_WIDTH and CNT_WIDTH.
- Sub-module tick_gen_prescaler holds the DIV_WIDTH counter.
  - Ports: clk, rst, clr, en, div_eff, wrap.
  - wrap is high combinationally when count==div_eff-1 and en=1.
- The top holds the FSM, the remaining counter, and the output registers.

Test Plan:
- Reset: hold rst=1 for 2 cycles mid-burst, then release -> tick, busy, done and remaining read 0 immediately on assert. A later start behaves as from power-up.
- Burst: div=4, n_ticks=3, start at E0 -> tick high after E4, E8, E12. done high only after E12. busy=0 after E12. remaining steps 3,2,1,0.
- div=0 edge case: div=0, n_ticks=5 -> tick high for 5 consecutive cycles after E1..E5. done with the 5th tick. Counter downstream advances by exactly 5.
- Free-run and stop: div=3, n_ticks=0 -> ticks every 3 cycles, remaining stays 0. Assert stop at E10 -> no tick after E10, busy=0, done never asserted.
- Collisions:
  - start while busy -> ignored, tick spacing unchanged.
  - stop on the edge of the final tick with div=2, n_ticks=2 -> tick and done both asserted after E4.
- Back-to-back: start on the done cycle with div=2, n_ticks=1 -> new busy=1 with no gap. Next tick follows 2 cycles later.

Source files
------------

// File: rtl/tick_gen_pkg.sv
// Shared types and defaults for the tick generator.
// Holds the FSM state enum and default widths.
package tick_gen_pkg;

    localparam int DIV_WIDTH_DEF = 8;
    localparam int CNT_WIDTH_DEF = 8;

    typedef enum logic {
        IDLE,
        RUN
    } tick_gen_state_t;

endpackage

// File: rtl/tick_gen_if.sv
// Control/status bundle of the tick generator.
// master: start, stop, div, n_ticks out; tick, busy, done, remaining in.
interface tick_gen_if
    import tick_gen_pkg::*;
#(
    parameter int DIV_WIDTH = DIV_WIDTH_DEF,
    parameter int CNT_WIDTH = CNT_WIDTH_DEF
) ();

    logic                 start;
    logic                 stop;
    logic [DIV_WIDTH-1:0] div;
    logic [CNT_WIDTH-1:0] n_ticks;
    logic                 tick;
    logic                 busy;
    logic                 done;
    logic [CNT_WIDTH-1:0] remaining;

    modport master (
        output start, stop, div, n_ticks,
        input  tick, busy, done, remaining
    );

    modport slave (
        input  start, stop, div, n_ticks,
        output tick, busy, done, remaining
    );

endinterface

// File: rtl/tick_gen_prescaler.sv
// Period counter: counts 0..div_eff-1 while enabled.
// Ports: clk, rst, clr, en, div_eff in; wrap out (combinational).
module tick_gen_prescaler #(
    parameter int DIV_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clr,
    input  logic                 en,
    input  logic [DIV_WIDTH-1:0] div_eff,
    output logic                 wrap
);

    logic [DIV_WIDTH-1:0] count;
    logic                 at_top;

    assign at_top = (count == div_eff - DIV_WIDTH'(1));
    assign wrap   = en & at_top;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= at_top ? '0 : count + DIV_WIDTH'(1);
        end
    end

endmodule

// File: rtl/tick_gen.sv
// Programmable tick generator: burst or free-run tick pulses.
// Ports: clk, rst; bus (slave) carries control and status.
module tick_gen
    import tick_gen_pkg::*;
#(
    parameter int DIV_WIDTH = DIV_WIDTH_DEF,
    parameter int CNT_WIDTH = CNT_WIDTH_DEF
) (
    input logic     clk,
    input logic     rst,
    tick_gen_if.slave bus
);

    tick_gen_state_t      state;
    tick_gen_state_t      state_nxt;

    logic [DIV_WIDTH-1:0] div_eff;
    logic                 free;
    logic [CNT_WIDTH-1:0] rem_q;
    logic [CNT_WIDTH-1:0] rem_nxt;
    logic                 tick_q;
    logic                 done_q;

    logic                 wrap;
    logic                 last;
    logic                 load;
    logic                 en;
    logic                 clr;

    // A due tick with one left ends the burst, even if stop arrives.
    assign last = wrap & ~free & (rem_q == CNT_WIDTH'(1));

    tick_gen_prescaler #(
        .DIV_WIDTH (DIV_WIDTH)
    ) u_pre (
        .clk     (clk),
        .rst     (rst),
        .clr     (clr),
        .en      (en),
        .div_eff (div_eff),
        .wrap    (wrap)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (bus.start) state_nxt = RUN;
            RUN:  if (bus.stop || last) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        load    = 1'b0;
        en      = 1'b0;
        clr     = 1'b1;
        rem_nxt = rem_q;
        unique case (state)
            IDLE: begin
                load = bus.start;
                if (bus.start) rem_nxt = bus.n_ticks;
            end
            RUN: begin
                en  = 1'b1;
                clr = bus.stop;
                if (bus.stop) begin
                    rem_nxt = '0;
                end else if (wrap && !free && rem_q != '0) begin
                    rem_nxt = rem_q - CNT_WIDTH'(1);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tick_q  <= 1'b0;
            done_q  <= 1'b0;
            rem_q   <= '0;
            div_eff <= DIV_WIDTH'(1);
            free    <= 1'b0;
        end else begin
            tick_q <= wrap;
            done_q <= last;
            rem_q  <= rem_nxt;
            if (load) begin
                div_eff <= (bus.div == '0) ? DIV_WIDTH'(1) : bus.div;
                free    <= (bus.n_ticks == '0);
            end
        end
    end

    assign bus.tick      = tick_q;
    assign bus.done      = done_q;
    assign bus.busy      = (state == RUN);
    assign bus.remaining = rem_q;

endmodule

// File: tb/tb_tick_gen.sv
// Self-checking bench for tick_gen.
// Expected ticks are queued at start and popped as ticks appear.
module tb_tick_gen;
    import tick_gen_pkg::*;

    typedef struct {
        int   cyc;
        logic done;
        int   rem;
    } exp_t;

    logic clk;
    logic rst;
    int   cyc;
    int   n_tests;
    int   n_fail;
    int   tick_cnt;
    exp_t q[$];

    tick_gen_if #(.DIV_WIDTH(8), .CNT_WIDTH(8)) bus ();

    tick_gen #(
        .DIV_WIDTH (8),
        .CNT_WIDTH (8)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag,
                       input logic [63:0] obs,
                       input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d want %0d", tag, obs, exp);
        end
    endtask

    // Monitor: every tick must match the head of the expected queue.
    always @(negedge clk) begin
        if (bus.tick === 1'b1) begin
            tick_cnt++;
            if (q.size() == 0) begin
                chk("tick_extra", 64'(bus.tick), 64'd0);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("tick_cyc", 64'(cyc), 64'(e.cyc));
                chk("tick_done", 64'(bus.done), 64'(e.done));
                chk("tick_rem", 64'(bus.remaining), 64'(e.rem));
            end
        end else if (bus.done === 1'b1) begin
            chk("done_lone", 64'(bus.done), 64'd0);
        end
    end

    task automatic to_cyc(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    // Drive start on a negedge; E0 is the following posedge.
    task automatic go(input int d, input int n, input int nexp,
                      output int e0);
        int deff;
        deff         = (d == 0) ? 1 : d;
        bus.div      = 8'(d);
        bus.n_ticks  = 8'(n);
        bus.start    = 1'b1;
        e0           = cyc + 1;
        for (int k = 1; k <= nexp; k++) begin
            exp_t e;
            e.cyc  = e0 + k * deff;
            e.done = (n != 0) && (k == n);
            e.rem  = (n != 0) ? n - k : 0;
            q.push_back(e);
        end
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic drain(input string tag, input int bound);
        for (int i = 0; i < bound && q.size() != 0; i++) @(negedge clk);
        chk(tag, 64'(q.size()), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int e0;
        int e1;
        int c0;
        n_tests     = 0;
        n_fail      = 0;
        tick_cnt    = 0;
        rst         = 1'b1;
        bus.start   = 1'b0;
        bus.stop    = 1'b0;
        bus.div     = '0;
        bus.n_ticks = '0;
        repeat (2) @(negedge clk);
        chk("rst_tick", 64'(bus.tick), 64'd0);
        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk("rst_done", 64'(bus.done), 64'd0);
        chk("rst_rem", 64'(bus.remaining), 64'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Burst div=4 n=3, with an ignored start mid-burst.
        go(4, 3, 3, e0);
        chk("b_busy", 64'(bus.busy), 64'd1);
        chk("b_rem3", 64'(bus.remaining), 64'd3);
        to_cyc(e0 + 5);
        chk("b_rem2", 64'(bus.remaining), 64'd2);
        bus.start   = 1'b1;
        bus.div     = 8'd1;
        bus.n_ticks = 8'd7;
        to_cyc(e0 + 6);
        bus.start = 1'b0;
        to_cyc(e0 + 9);
        chk("b_rem1", 64'(bus.remaining), 64'd1);
        to_cyc(e0 + 12);
        chk("b_busy_end", 64'(bus.busy), 64'd0);
        chk("b_rem0", 64'(bus.remaining), 64'd0);
        drain("b_drain", 20);
        repeat (3) @(negedge clk);

        // div=0 behaves as 1: five back-to-back ticks.
        c0 = tick_cnt;
        go(0, 5, 5, e0);
        to_cyc(e0 + 5);
        chk("d0_busy", 64'(bus.busy), 64'd0);
        to_cyc(e0 + 8);
        chk("d0_count", 64'(tick_cnt - c0), 64'd5);
        drain("d0_drain", 10);

        // Free-run div=3, stopped at E10.
        go(3, 0, 3, e0);
        to_cyc(e0 + 4);
        chk("f_rem", 64'(bus.remaining), 64'd0);
        to_cyc(e0 + 9);
        bus.stop = 1'b1;
        to_cyc(e0 + 10);
        bus.stop = 1'b0;
        chk("f_busy", 64'(bus.busy), 64'd0);
        chk("f_tick", 64'(bus.tick), 64'd0);
        to_cyc(e0 + 16);
        drain("f_drain", 5);

        // Stop on the final-tick edge: done still asserted.
        go(2, 2, 2, e0);
        to_cyc(e0 + 3);
        bus.stop = 1'b1;
        to_cyc(e0 + 4);
        bus.stop = 1'b0;
        chk("c_busy", 64'(bus.busy), 64'd0);
        drain("c_drain", 10);
        repeat (3) @(negedge clk);

        // Back-to-back: restart on the done cycle, stop alongside.
        go(2, 1, 1, e0);
        to_cyc(e0 + 2);
        chk("bb_done", 64'(bus.done), 64'd1);
        bus.stop = 1'b1;
        go(2, 1, 1, e1);
        bus.stop = 1'b0;
        chk("bb_e1", 64'(e1), 64'(e0 + 3));
        chk("bb_busy", 64'(bus.busy), 64'd1);
        to_cyc(e1 + 2);
        chk("bb_busy_end", 64'(bus.busy), 64'd0);
        drain("bb_drain", 10);
        repeat (3) @(negedge clk);

        // Reset mid-burst while tick is high.
        go(4, 10, 10, e0);
        to_cyc(e0 + 4);
        #2 rst = 1'b1;
        #1;
        chk("mr_tick", 64'(bus.tick), 64'd0);
        chk("mr_busy", 64'(bus.busy), 64'd0);
        chk("mr_done", 64'(bus.done), 64'd0);
        chk("mr_rem", 64'(bus.remaining), 64'd0);
        q.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("mr_idle", 64'(bus.busy), 64'd0);
        go(1, 2, 2, e0);
        chk("mr_rem2", 64'(bus.remaining), 64'd2);
        to_cyc(e0 + 2);
        chk("mr_busy_end", 64'(bus.busy), 64'd0);
        drain("mr_drain", 10);
        repeat (5) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
